vrot_arb: RTL and testbench
===========================

VROT_ARB -- requirements
Module: vrot_arb

Interface
- REQ-001: Parameter NUM_REQ, default 2, number of requesters sharing the rotate datapath; legal range 2..8.
- REQ-002: Parameter ID_W, default $clog2(NUM_REQ), width of requester index.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous active-low reset.
- REQ-005: req_valid  input  NUM_REQ  per-requester operation valid.
- REQ-006: req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- REQ-007: req_state  input  NUM_REQ x 128  per-requester 4x32-bit lane data.
- REQ-008: req_rot  input  NUM_REQ x 128  per-requester rotate amounts; bits [32i+4:32i] are used for lane i, all other bits ignored.
- REQ-009: rsp_valid  output  1  result register holds a valid result.
- REQ-010: rsp_ready  input  1  consumer accept.
- REQ-011: rsp_state  output  128  rotated result.
- REQ-012: rsp_id  output  ID_W  index of the requester that issued the result.

Function
- REQ-013: Lane i result = req_state lane i rotated right by amount n = req_rot[32i+4:32i]; n=0 returns the lane unchanged; lanes are independent.
- REQ-014: Transfer on a request port occurs when req_valid[k] and req_ready[k] are high in the same cycle; transfer on the response port occurs when rsp_valid and rsp_ready are high in the same cycle.
- REQ-015: Latency is exactly 1 cycle: an operation accepted in cycle t appears with rsp_valid=1 in cycle t+1.
- REQ-016: Output stage is one 128+ID_W bit register plus a valid flag; the block holds no other data storage.
- REQ-017: can_accept = !rsp_valid | rsp_ready; req_ready is all-zero when can_accept=0.
- REQ-018: When can_accept=1, grant goes to the first requester with req_valid high, searching from ptr upward modulo NUM_REQ; req_ready is one-hot on that requester.
- REQ-019: ptr resets to 0; on each request transfer, ptr <= granted index + 1, wrapping NUM_REQ-1 -> 0; ptr is unchanged when no request transfer occurs.
- REQ-020: Simultaneous response drain and new grant in the same cycle: the register reloads, rsp_valid stays 1, and throughput is 1 op/cycle with no bubble.
- REQ-021: Drain with no grant: rsp_valid <= 0.
- REQ-022: While rsp_valid=1 and rsp_ready=0, rsp_state and rsp_id are held stable.
- REQ-023: req_ready is a combinational function of req_valid, ptr, rsp_valid and rsp_ready only; it does not depend on req_state or req_rot.
- REQ-024: A requester whose req_valid is high is granted within NUM_REQ grants (starvation-free).

Reset
- REQ-025: Reset asserted (asynchronously) sets rsp_valid=0, rsp_state=0, rsp_id=0, ptr=0 and, when compiled in, all perf counters to 0.
- REQ-026: Reset mid-operation discards the held result without a handshake.
- REQ-027: req_ready is all-zero while rst_n=0.
- REQ-028: After rst_n deasserts, the first grant may occur in the first clock cycle.

Configuration
- REQ-029: Macro VROT_ARB_PERF_EN.
- REQ-030: With VROT_ARB_PERF_EN defined, the block adds output perf_grant_cnt (NUM_REQ x 32): the count of transfers per requester.
- REQ-031: With VROT_ARB_PERF_EN defined, the block adds output perf_stall_cnt (32): the count of cycles with rsp_valid=1 and rsp_ready=0.
- REQ-032: All perf counters saturate at 0xFFFFFFFF.
- REQ-033: Without VROT_ARB_PERF_EN, these ports and their counters are absent, and the remaining behaviour is identical.

Structure
- REQ-034: Shared package vrot_pkg holds VROT_LANES=4, VROT_LANE_W=32, VROT_AMT_W=5 and typedef vrot_vec_t (logic [127:0]).
- REQ-035: The rotate datapath is a single instance of the existing combinational sub-module vrot32, driven by the granted requester's muxed state and amounts.
- REQ-036: Arbitration, pointer, output register and counters reside in vrot_arb.

Verification
- REQ-037: Single op: req0 state lanes all 0x80000001, rot lanes {1,4,0,31}, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, lanes {0xC0000000, 0x18000000, 0x80000001, 0x00000003}.
- REQ-038: Both requesters valid continuously, rsp_ready=1, after reset -> grants alternate 0,1,0,1; rsp_valid stays 1 from cycle 1; no bubbles.
- REQ-039: Backpressure: result held, rsp_ready=0 for 3 cycles -> rsp_state and rsp_id stable, req_ready=0 throughout, and with PERF_EN perf_stall_cnt=3.
- REQ-040: Drain and accept in the same cycle: rsp_ready=1 with req1 valid -> register reloads with req1's result and rsp_valid stays 1.
- REQ-041: Reset asserted while rsp_valid=1 -> rsp_valid=0 immediately without a clock edge; after release, ptr=0 so req0 wins a tie.
- REQ-042: Rotate amount bits above bit 4 set (rot lane=0xFFFFFFE3) -> lane rotated right by 3.

Source files
------------

// File: rtl/vrot_pkg.sv
// Shared constants and types for the lane-rotate datapath.
package vrot_pkg;

    localparam int VROT_LANES  = 4;
    localparam int VROT_LANE_W = 32;
    localparam int VROT_AMT_W  = 5;

    typedef logic [VROT_LANES*VROT_LANE_W-1:0] vrot_vec_t;
    typedef logic [VROT_LANES-1:0][VROT_AMT_W-1:0] vrot_amt_t;

endpackage

// File: rtl/vrot32.sv
// Combinational rotate-right of four independent 32-bit lanes.
module vrot32
    import vrot_pkg::*;
(
    input  vrot_vec_t state_in,
    input  vrot_amt_t amt,
    output vrot_vec_t state_out
);

    logic [2*VROT_LANE_W-1:0] dbl;

    // Rotate each lane by shifting a doubled copy; amount 0 leaves the lane as-is.
    always_comb begin
        state_out = '0;
        dbl       = '0;
        for (int l = 0; l < VROT_LANES; l++) begin
            dbl = {state_in[l*VROT_LANE_W +: VROT_LANE_W],
                   state_in[l*VROT_LANE_W +: VROT_LANE_W]} >> amt[l];
            state_out[l*VROT_LANE_W +: VROT_LANE_W] = dbl[VROT_LANE_W-1:0];
        end
    end

endmodule

// File: rtl/vrot_arb.sv
// Round-robin arbiter in front of a shared lane-rotate unit with a single
// output register (1-cycle latency, full throughput).
// Optional perf counters are compiled in with VROT_ARB_PERF_EN.
module vrot_arb
    import vrot_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  vrot_vec_t [NUM_REQ-1:0]     req_state,
    input  vrot_vec_t [NUM_REQ-1:0]     req_rot,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output vrot_vec_t                   rsp_state,
    output logic [ID_W-1:0]             rsp_id
`ifdef VROT_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]    perf_grant_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    logic            can_accept;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic            req_xfer;
    vrot_vec_t       sel_state;
    vrot_vec_t       sel_rot;
    vrot_amt_t       sel_amt;
    vrot_vec_t       rot_out;
    logic            unused_rot_bits;

    assign can_accept = !rsp_valid || rsp_ready;
    assign req_xfer   = |(req_valid & req_ready);

    // Pick the first valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    // One-hot accept, suppressed while the output register cannot take data or in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && can_accept && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    assign sel_state = req_state[gnt_idx];
    assign sel_rot   = req_rot[gnt_idx];

    // Only the low five bits of each 32-bit amount lane steer the rotate.
    always_comb begin
        sel_amt = '0;
        for (int l = 0; l < VROT_LANES; l++) begin
            sel_amt[l] = sel_rot[l*VROT_LANE_W +: VROT_AMT_W];
        end
    end

    assign unused_rot_bits = ^sel_rot;

    vrot32 u_vrot32 (
        .state_in  (sel_state),
        .amt       (sel_amt),
        .state_out (rot_out)
    );

    // Output register and round-robin pointer; reload on grant, clear on bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_state <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (req_xfer) begin
            rsp_valid <= 1'b1;
            rsp_state <= rot_out;
            rsp_id    <= gnt_idx;
            ptr       <= ptr_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef VROT_ARB_PERF_EN
    // Saturating per-requester grant counters and output stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && req_ready[k] && perf_grant_cnt[k] != 32'hFFFF_FFFF) begin
                    perf_grant_cnt[k] <= perf_grant_cnt[k] + 32'd1;
                end
            end
            if (rsp_valid && !rsp_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vrot_arb.sv
// Directed plus random stimulus against a transaction-level model of vrot_arb.
module tb_vrot_arb;

    localparam int NR = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0][127:0] req_state;
    logic [NR-1:0][127:0] req_rot;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [127:0]         rsp_state;
    logic [0:0]           rsp_id;
`ifdef VROT_ARB_PERF_EN
    logic [NR-1:0][31:0]  perf_grant_cnt;
    logic [31:0]          perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // model state
    logic         m_vld;
    logic [127:0] m_state;
    int           m_id;
    int           m_ptr;
    int           m_gcnt[NR];
    int           m_stall;
    logic [127:0] held;

    always #5 clk = ~clk;

    vrot_arb #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .req_rot   (req_rot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_state (rsp_state),
        .rsp_id    (rsp_id)
`ifdef VROT_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rotate each lane right one bit at a time, n times.
    function automatic logic [127:0] ref_rot(input logic [127:0] s, input logic [127:0] r);
        logic [127:0] res;
        logic [31:0]  w;
        int           n;
        res = '0;
        for (int l = 0; l < 4; l++) begin
            w = s[32*l +: 32];
            n = int'(r[32*l +: 5]);
            for (int j = 0; j < n; j++) w = {w[0], w[31:1]};
            res[32*l +: 32] = w;
        end
        return res;
    endfunction

    task automatic model_reset();
        m_vld   = 1'b0;
        m_state = '0;
        m_id    = 0;
        m_ptr   = 0;
        m_stall = 0;
        for (int k = 0; k < NR; k++) m_gcnt[k] = 0;
    endtask

    // One clock: check accept decision, advance model at the edge, check result register.
    task automatic cycle();
        logic [NR-1:0] er;
        int            g;
        int            k;
        #1;
        er = '0;
        g  = -1;
        if (!m_vld || rsp_ready) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(er));
        @(posedge clk);
        if (m_vld && !rsp_ready) m_stall++;
        if (g >= 0) begin
            m_vld   = 1'b1;
            m_state = ref_rot(req_state[g], req_rot[g]);
            m_id    = g;
            m_ptr   = (g + 1) % NR;
            m_gcnt[g]++;
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
        #1;
        chk("rsp_valid", 128'(rsp_valid), 128'(m_vld));
        if (m_vld) begin
            chk("rsp_state", rsp_state, m_state);
            chk("rsp_id", 128'(rsp_id), 128'(m_id));
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        // reset state
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_state = {rnd128(), rnd128()};
        req_rot   = {rnd128(), rnd128()};
        model_reset();
        #2;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_state", rsp_state, 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single operation on requester 0
        req_valid    = 2'b01;
        req_state[0] = {4{32'h8000_0001}};
        req_rot[0]   = {32'd31, 32'd0, 32'd4, 32'd1};
        cycle();
        chk("single_state", rsp_state,
            {32'h0000_0003, 32'h8000_0001, 32'h1800_0000, 32'hC000_0000});
        chk("single_id", 128'(rsp_id), 128'(0));
        chk("single_valid", 128'(rsp_valid), 128'(1));

        // both valid continuously: alternating grants, no bubbles
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            req_state = {rnd128(), rnd128()};
            req_rot   = {rnd128(), rnd128()};
            cycle();
            chk("stream_valid", 128'(rsp_valid), 128'(1));
        end

        // backpressure for three cycles
        held      = rsp_state;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_state = {rnd128(), rnd128()};
            cycle();
            chk("bp_hold", rsp_state, held);
        end
`ifdef VROT_ARB_PERF_EN
        chk("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
`endif

        // drain and accept in the same cycle, requester 1 only
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        req_state = {rnd128(), rnd128()};
        cycle();
        chk("reload_id", 128'(rsp_id), 128'(1));
        chk("reload_valid", 128'(rsp_valid), 128'(1));

        // drain with nothing requesting
        req_valid = 2'b00;
        cycle();

        // reset while holding a result
        req_valid = 2'b11;
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 128'(rsp_valid), 128'(0));
        chk("async_rst_state", rsp_state, 128'(0));
        chk("async_rst_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_tie", 128'(rsp_id), 128'(0));

        // high amount bits ignored
        req_valid    = 2'b10;
        req_state[1] = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0000_000F;
        req_rot[1]   = {4{32'hFFFF_FFE3}};
        cycle();
        chk("rot_hi_bits", rsp_state,
            {32'hE024_68AC, 32'hF135_79BD, 32'hFBD5_B7DD, 32'hE000_0001});

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_state = {rnd128(), rnd128()};
            req_rot   = {rnd128(), rnd128()};
            cycle();
        end

`ifdef VROT_ARB_PERF_EN
        for (int k = 0; k < NR; k++) chk("perf_grant", 128'(perf_grant_cnt[k]), 128'(m_gcnt[k]));
        chk("perf_stall_end", 128'(perf_stall_cnt), 128'(m_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
